// File: rtl/fir_sample_sequencer.sv
// Sample playback sequencer: reads stored samples from a 1-cycle-latency RAM and
// hands them one at a time to the FIR filter over a valid/ready handshake.
module fir_sample_sequencer #(
   parameter int N     = 16,
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          stop,
   input  logic          loop_en,
   input  logic [AW-1:0] len,
   output logic [AW-1:0] mem_addr,
   input  logic [N-1:0]  mem_rdata,
   output logic [N-1:0]  fir_data,
   output logic          fir_valid,
   input  logic          fir_ready,
   output logic          busy,
   output logic          done,
   output logic [15:0]   sample_cnt
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_LOAD = 3'd2,
      S_OUT  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // len_q is one bit wider than an address so that a full DEPTH pass fits.
   localparam logic [AW:0]   DEPTH_L  = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] ADDR_ONE = AW'(1);

   state_t        state_q, state_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [N-1:0]  fir_data_q, fir_data_d;
   logic          fir_valid_q, fir_valid_d;
   logic [15:0]   sample_cnt_q, sample_cnt_d;
   logic          stop_pend_q, stop_pend_d;
   logic [AW:0]   len_q, len_d;
   logic          loop_q, loop_d;

   logic handshake;
   logic last;

   assign handshake = fir_valid_q & fir_ready;
   assign last      = ({1'b0, mem_addr_q} == (len_q - LEN_ONE));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         mem_addr_q   <= '0;
         fir_data_q   <= '0;
         fir_valid_q  <= 1'b0;
         sample_cnt_q <= '0;
         stop_pend_q  <= 1'b0;
         len_q        <= DEPTH_L;
         loop_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_addr_q   <= mem_addr_d;
         fir_data_q   <= fir_data_d;
         fir_valid_q  <= fir_valid_d;
         sample_cnt_q <= sample_cnt_d;
         stop_pend_q  <= stop_pend_d;
         len_q        <= len_d;
         loop_q       <= loop_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      mem_addr_d   = mem_addr_q;
      fir_data_d   = fir_data_q;
      fir_valid_d  = fir_valid_q;
      sample_cnt_d = sample_cnt_q;
      stop_pend_d  = stop_pend_q;
      len_d        = len_q;
      loop_d       = loop_q;
      case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               len_d        = (len == '0) ? DEPTH_L : {1'b0, len};
               loop_d       = loop_en;
               mem_addr_d   = '0;
               sample_cnt_d = '0;
               stop_pend_d  = 1'b0;
               state_d      = S_RD;
            end
         end
         S_RD: begin
            state_d = stop ? S_DONE : S_LOAD;
         end
         S_LOAD: begin
            if (stop) begin
               state_d = S_DONE;
            end else begin
               fir_data_d  = mem_rdata;
               fir_valid_d = 1'b1;
               state_d     = S_OUT;
            end
         end
         S_OUT: begin
            if (handshake) begin
               fir_valid_d  = 1'b0;
               sample_cnt_d = sample_cnt_q + 16'd1;
               if (stop_pend_q || stop || (last && !loop_q)) begin
                  state_d = S_DONE;
               end else begin
                  mem_addr_d = last ? '0 : mem_addr_q + ADDR_ONE;
                  state_d    = S_RD;
               end
            end else if (stop) begin
               // Remember the stop; the offered sample must still be delivered.
               stop_pend_d = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      busy = (state_q == S_RD) || (state_q == S_LOAD) || (state_q == S_OUT);
      done = (state_q == S_DONE);
   end

   assign mem_addr   = mem_addr_q;
   assign fir_data   = fir_data_q;
   assign fir_valid  = fir_valid_q;
   assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Bench for fir_sample_sequencer: table-driven and randomized playback runs checked
// against a transfer-level model of the expected sample stream, plus corner sequences.
module tb_fir_sample_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        loop_en = 1'b0;
   logic [4:0]  len = '0;
   logic [4:0]  mem_addr;
   logic [15:0] mem_rdata = '0;
   logic [15:0] fir_data;
   logic        fir_valid;
   logic        fir_ready = 1'b0;
   logic        busy;
   logic        done;
   logic [15:0] sample_cnt;

   logic [15:0] mem [32];

   int vec_cnt = 0;
   int err_cnt = 0;
   int cyc = 0;

   typedef struct {
      int len_in;
      bit lp;
      int stop_at;
      int rdy_pct;
      int exp_cnt;
   } vec_t;

   vec_t vecs [10];

   fir_sample_sequencer #(.N(16), .DEPTH(32), .AW(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .loop_en    (loop_en),
      .len        (len),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .fir_data   (fir_data),
      .fir_valid  (fir_valid),
      .fir_ready  (fir_ready),
      .busy       (busy),
      .done       (done),
      .sample_cnt (sample_cnt)
   );

   always #5 clk = ~clk;

   // Sample RAM with one cycle of read latency.
   always @(posedge clk) mem_rdata <= mem[mem_addr];

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fill_mem(input bit rnd);
      for (int i = 0; i < 32; i++) mem[i] = rnd ? 16'($urandom) : 16'(i + 1);
   endtask

   // One playback run. The model only knows the playback rules: the k-th transfer
   // carries mem[k mod L], playback ends after L transfers (single pass) or on the
   // transfer that coincides with / follows a stop.
   task automatic run_playback(input int len_in, input bit lp, input int stop_at,
                               input int rdy_pct, input int exp_cnt);
      int          le, exp_addr, ntx, budget, last_hs;
      bit          stop_pend, exp_done, fin, prev_hold, last;
      logic [15:0] held;
      le = (len_in == 0) ? 32 : len_in;
      exp_addr = 0; ntx = 0; budget = 0; last_hs = -1;
      stop_pend = 0; exp_done = 0; fin = 0; prev_hold = 0; held = '0;
      start = 1'b1; len = len_in[4:0]; loop_en = lp; stop = 1'b0; fir_ready = 1'b0;
      step();
      while (!fin) begin
         start = 1'b0;
         stop = 1'b0;
         fir_ready = ($urandom_range(99) < rdy_pct);
         // Mid-run control noise that must not disturb the captured settings.
         len = 5'($urandom);
         loop_en = 1'($urandom);
         if (fir_valid && !stop_pend && stop_at >= 0 && ntx == stop_at) begin
            stop = 1'b1;
            stop_pend = 1'b1;
         end
         if (fir_valid && $urandom_range(3) == 0) start = 1'b1;
         check("done", done, exp_done);
         if (exp_done) begin
            check("busy_in_done", busy, 0);
            check("transfers", ntx, exp_cnt);
            check("sample_cnt", sample_cnt, exp_cnt);
            fin = 1;
         end else begin
            check("busy", busy, 1);
            check("addr_range", (mem_addr < le), 1);
            if (prev_hold) begin
               check("valid_hold", fir_valid, 1);
               check("data_hold", fir_data, held);
            end
            if (fir_valid && fir_ready) begin
               check("fir_data", fir_data, mem[exp_addr]);
               check("mem_addr", mem_addr, exp_addr);
               if (rdy_pct >= 100 && last_hs >= 0) check("interval", cyc - last_hs, 3);
               last_hs = cyc;
               ntx++;
               last = (exp_addr == le - 1);
               exp_addr = last ? 0 : exp_addr + 1;
               exp_done = stop_pend || (last && !lp);
            end
            prev_hold = fir_valid && !fir_ready;
            held = fir_data;
         end
         budget++;
         if (!fin && budget > 200 + 40 * exp_cnt) begin
            check("timeout", 1, 0);
            fin = 1;
         end
         if (!fin) step();
      end
      start = 1'b0; stop = 1'b0;
      step();
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      $display("run len=%0d loop=%0d stop_at=%0d ready%%=%0d transfers=%0d", len_in, lp, stop_at,
               rdy_pct, ntx);
   endtask

   initial begin
      int hs, n, le, sa, ec;
      bit lp, seen;

      vecs[0] = '{4, 1'b0, -1, 100, 4};
      vecs[1] = '{0, 1'b0, -1, 100, 32};
      vecs[2] = '{0, 1'b1, 37, 100, 38};
      vecs[3] = '{2, 1'b0, -1, 50, 2};
      vecs[4] = '{7, 1'b1, 20, 60, 21};
      vecs[5] = '{1, 1'b0, -1, 100, 1};
      vecs[6] = '{1, 1'b1, 5, 30, 6};
      vecs[7] = '{31, 1'b0, -1, 70, 31};
      vecs[8] = '{5, 1'b0, 2, 40, 3};
      vecs[9] = '{3, 1'b1, 0, 100, 1};

      fill_mem(0);
      #1;
      check("rst_valid", fir_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      repeat (3) step();
      reset = 1'b0;
      step();
      check("rst_cnt", sample_cnt, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_data", fir_data, 0);

      for (int i = 0; i < 10; i++) begin
         fill_mem(i != 0);
         run_playback(vecs[i].len_in, vecs[i].lp, vecs[i].stop_at, vecs[i].rdy_pct,
                      vecs[i].exp_cnt);
      end

      for (int i = 0; i < 12; i++) begin
         fill_mem(1);
         n  = $urandom_range(31);
         le = (n == 0) ? 32 : n;
         lp = 1'($urandom);
         if (lp) sa = $urandom_range(2 * le);
         else sa = ($urandom_range(1) == 0) ? -1 : $urandom_range(le - 1);
         ec = (sa < 0) ? le : sa + 1;
         run_playback(n, lp, sa, $urandom_range(30, 100), ec);
      end

      // Backpressure: first sample held for 5 cycles, then two transfers total.
      fill_mem(0);
      start = 1'b1; len = 5'd2; loop_en = 1'b0; fir_ready = 1'b0;
      step();
      start = 1'b0;
      n = 0;
      while (!fir_valid && n < 6) begin step(); n++; end
      for (int k = 0; k < 5; k++) begin
         check("bp_valid", fir_valid, 1);
         check("bp_data", fir_data, 16'd1);
         step();
      end
      fir_ready = 1'b1;
      hs = 0; seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (done) seen = 1;
         else begin
            if (fir_valid && fir_ready) hs++;
            step();
         end
      end
      check("bp_done_seen", seen, 1);
      check("bp_transfers", hs, 2);
      check("bp_cnt", sample_cnt, 2);
      $display("backpressure sequence transfers=%0d", hs);
      step();

      // Stop in the first RD cycle.
      start = 1'b1; len = 5'd4; fir_ready = 1'b1;
      step();
      start = 1'b0; stop = 1'b1;
      step();
      stop = 1'b0;
      check("rdstop_done", done, 1);
      check("rdstop_valid", fir_valid, 0);
      check("rdstop_cnt", sample_cnt, 0);
      step();
      check("rdstop_busy", busy, 0);
      $display("stop in RD sequence");

      // Stop in LOAD.
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("ldstop_done", done, 1);
      check("ldstop_valid", fir_valid, 0);
      check("ldstop_cnt", sample_cnt, 0);
      step();
      $display("stop in LOAD sequence");

      // start together with stop in IDLE does nothing.
      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      check("ss_busy", busy, 0);
      step();
      check("ss_busy2", busy, 0);
      check("ss_done", done, 0);
      $display("start+stop in IDLE sequence");

      // Async reset while a sample is on offer.
      start = 1'b1; len = 5'd8; loop_en = 1'b1; fir_ready = 1'b0;
      step();
      start = 1'b0;
      n = 0;
      while (!fir_valid && n < 6) begin step(); n++; end
      check("pre_rst_valid", fir_valid, 1);
      #2 reset = 1'b1;
      #1;
      check("async_valid", fir_valid, 0);
      check("async_busy", busy, 0);
      step();
      reset = 1'b0;
      step();
      check("post_rst_busy", busy, 0);
      check("post_rst_done", done, 0);
      check("post_rst_cnt", sample_cnt, 0);
      check("post_rst_addr", mem_addr, 0);
      $display("reset during OUT sequence");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
